pcie_vc_switch: RTL and testbench
=================================

Name: pcie_vc_switch

Overview:
- Parametrised successor of the 2-VC / 2-destination interconnect.
- Incoming words are steered by class bits into NUM_VC virtual-channel FIFOs.
- A round-robin arbiter moves one word per cycle to one of NUM_DEST destination FIFOs, selected by the word's destination bits, with per-destination backpressure.
- A control FSM (RESET/INIT/IDLE/ACTIVE/ERROR) latches thresholds and reports status and sticky error flags.

Parameters:
WORD_SIZE, 6, data word width; must be >= VC_W and >= DEST_W
NUM_VC, 4, number of virtual channels (power of 2, >=2); VC_W = log2(NUM_VC)
NUM_DEST, 4, number of destination FIFOs (power of 2, >=2); DEST_W = log2(NUM_DEST)
VC_DEPTH, 16, entries per VC FIFO
D_DEPTH, 4, entries per destination FIFO
PTR_L, 5, threshold/count width; must hold VC_DEPTH and D_DEPTH

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  synchronous, active-high reset
init  input  1  enter/stay in INIT and latch thresholds
umbral_V_full  input  PTR_L  VC almost-full threshold
umbral_D_full  input  PTR_L  destination almost-full threshold
data_in  input  WORD_SIZE  incoming word; VC = data_in[WORD_SIZE-1 -: VC_W], dest = data_in[DEST_W-1:0]
push_data_in  input  1  write data_in this cycle
input_pause  output  1  any VC count >= latched VC threshold
pop_D  input  NUM_DEST  per-destination pop
data_out  output  NUM_DEST*WORD_SIZE  destination FIFO heads; slice j = dest j
d_empty  output  NUM_DEST  destination FIFO empty flags
errors  output  NUM_VC+NUM_DEST  sticky flags: [i] VC i overflow; [NUM_VC+j] dest j underflow/overflow
error_out  output  1  FSM in ERROR
active_out  output  1  FSM in ACTIVE
idle_out  output  1  FSM in IDLE
state  output  3  encoded state: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4

Behaviour:
- Reset (sync, wins over all else): all FIFOs emptied, pointers/counts 0, RR pointer 0, errors 0, thresholds 0, state RESET. Outputs: error_out/active_out/idle_out/input_pause 0, d_empty all 1, data_out 0.
- RESET -> INIT unconditionally next cycle.
- INIT: latch umbral_V_full and umbral_D_full every cycle. A latched value of 0 or a value > depth is stored as the depth. Stay while init=1; init=0 -> IDLE.
- IDLE: all FIFOs empty. Any FIFO non-empty -> ACTIVE.
- ACTIVE: all FIFOs empty -> IDLE.
- From IDLE or ACTIVE: init=1 -> INIT (contents kept). Any new error bit -> ERROR (error has priority over init).
- ERROR: sticky until reset. Arbitration halted; pushes ignored; pop_D is still served.
- Push:
  - Accepted only in IDLE/ACTIVE/INIT.
  - Push to a full VC: word dropped and errors[vc] set.
  - Pushes in ERROR are ignored and do not set a flag.
- VC and destination FIFOs are first-word-fall-through; empty slices of data_out read 0.
- Arbiter, once per cycle, only in IDLE/ACTIVE:
  - VC i is eligible when it is non-empty and dest count of its head's destination < latched D threshold.
  - Grant goes to the first eligible VC at or after the RR pointer, searching upward with wrap.
  - On grant: VC popped, word written to that dest, pointer = grant+1 mod NUM_VC.
  - No eligible VC: pointer unchanged.
- Latency: word pushed at edge t is eligible in cycle t+1 and visible on data_out at t+2, when unblocked.
- Simultaneous events:
  - Push and grant on the same VC in one cycle: count unchanged. A full VC still overflows if pushed, since the pop is not credited.
  - pop_D and grant on the same dest in one cycle: both occur.
- pop_D[j] while d_empty[j]=1: no change except errors[NUM_VC+j] set.
- Dest overflow is unreachable given the threshold clamp. If it ever occurs, the word is dropped and the same bit is set.
- input_pause is registered: updated from post-edge counts, so it is valid the cycle after the push that crossed the threshold.

Optional Feature:
VC_STRICT_PRIO_EN:
- Defined: the arbiter grants the lowest-index eligible VC every cycle; the RR pointer is not implemented.
- Undefined: round-robin as specified.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, init=1 with V=8, D=2, then init=0 -> state INIT then IDLE. Push 0x23 -> data_out slice 3 = 0x23 and d_empty[3]=0 two cycles later, state ACTIVE. Pop_D[3] -> d_empty[3]=1, IDLE.
- Round-robin: D threshold=1. Push 0x00, then 0x30, 0x20, 0x10, 0x04 (all to dest0). Pulse pop_D[0] each cycle -> outputs 0x00, 0x10, 0x20, 0x30, 0x04. With VC_STRICT_PRIO_EN -> 0x00, 0x04, 0x10, 0x20, 0x30.
- Pause: V threshold=3, dest1 held full (D=1, no pops). Push three words 0x11 -> input_pause=1 the cycle after the third push. Pop dest1 until drained -> input_pause=0.
- Overflow: dest0 blocked. Push 17 words 0x00 to VC0 -> errors[0]=1, state ERROR, error_out=1, further pushes ignored. Reset -> errors 0, state RESET.
- Underflow: pop_D[2] when empty -> errors[NUM_VC+2]=1, ERROR. Pop_D[0] in ERROR still drains dest0.
- Reset mid-traffic: with 5 words in flight, assert reset one cycle -> all d_empty=1, input_pause=0, state RESET. Previously pushed data never appears.

Source files
------------

// File: rtl/pcie_vc_switch.sv
// rtl/pcie_vc_switch.sv - NUM_VC virtual-channel to NUM_DEST destination switch with control FSM
// Define VC_STRICT_PRIO_EN for fixed lowest-index-first arbitration instead of round-robin.
module pcie_vc_switch #(
    parameter int WORD_SIZE = 6,
    parameter int NUM_VC    = 4,
    parameter int NUM_DEST  = 4,
    parameter int VC_DEPTH  = 16,
    parameter int D_DEPTH   = 4,
    parameter int PTR_L     = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          init,
    input  logic [PTR_L-1:0]              umbral_V_full,
    input  logic [PTR_L-1:0]              umbral_D_full,
    input  logic [WORD_SIZE-1:0]          data_in,
    input  logic                          push_data_in,
    output logic                          input_pause,
    input  logic [NUM_DEST-1:0]           pop_D,
    output logic [NUM_DEST*WORD_SIZE-1:0] data_out,
    output logic [NUM_DEST-1:0]           d_empty,
    output logic [NUM_VC+NUM_DEST-1:0]    errors,
    output logic                          error_out,
    output logic                          active_out,
    output logic                          idle_out,
    output logic [2:0]                    state
);
    localparam int VC_W   = $clog2(NUM_VC);
    localparam int DEST_W = $clog2(NUM_DEST);
    localparam int VA_W   = (VC_DEPTH > 1) ? $clog2(VC_DEPTH) : 1;
    localparam int DA_W   = (D_DEPTH > 1) ? $clog2(D_DEPTH) : 1;
    localparam logic [PTR_L-1:0] VC_FULL = PTR_L'(VC_DEPTH);
    localparam logic [PTR_L-1:0] D_FULL  = PTR_L'(D_DEPTH);

    localparam logic [2:0] ST_RESET  = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_IDLE   = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

    logic [2:0]           state_nxt;
    logic [WORD_SIZE-1:0] vc_mem     [NUM_VC][VC_DEPTH];
    logic [VA_W-1:0]      vc_rd      [NUM_VC];
    logic [VA_W-1:0]      vc_wr      [NUM_VC];
    logic [PTR_L-1:0]     vc_cnt     [NUM_VC];
    logic [PTR_L-1:0]     vc_cnt_nxt [NUM_VC];
    logic [WORD_SIZE-1:0] vc_head    [NUM_VC];
    logic [WORD_SIZE-1:0] d_mem      [NUM_DEST][D_DEPTH];
    logic [DA_W-1:0]      d_rd       [NUM_DEST];
    logic [DA_W-1:0]      d_wr       [NUM_DEST];
    logic [PTR_L-1:0]     d_cnt      [NUM_DEST];
    logic [PTR_L-1:0]     d_cnt_nxt  [NUM_DEST];

    logic [PTR_L-1:0]     v_thr, d_thr, v_thr_in, d_thr_in, v_thr_nxt;
    logic [NUM_VC-1:0]    vc_we, vc_re, eligible;
    logic [NUM_DEST-1:0]  d_we, d_re;
    logic                 gnt_valid;
    logic [VC_W-1:0]      gnt_vc, scan_idx;
    logic [WORD_SIZE-1:0] gnt_word;
    logic [DEST_W-1:0]    gnt_dest;
    logic [NUM_VC+NUM_DEST-1:0] err_set;
    logic                 run, push_ok, any_busy, pause_nxt;
    logic [VC_W-1:0]      push_vc;
`ifndef VC_STRICT_PRIO_EN
    logic [VC_W-1:0]      rr_ptr;
`endif

    function automatic logic [VA_W-1:0] vc_inc(input logic [VA_W-1:0] p);
        return (p == VA_W'(VC_DEPTH - 1)) ? '0 : p + VA_W'(1);
    endfunction

    function automatic logic [DA_W-1:0] d_inc(input logic [DA_W-1:0] p);
        return (p == DA_W'(D_DEPTH - 1)) ? '0 : p + DA_W'(1);
    endfunction

    assign run      = (state == ST_IDLE) || (state == ST_ACTIVE);
    assign push_ok  = push_data_in && (run || (state == ST_INIT));
    assign push_vc  = data_in[WORD_SIZE-1 -: VC_W];
    // Zero or out-of-range thresholds collapse to the FIFO depth.
    assign v_thr_in = (umbral_V_full == '0 || umbral_V_full > VC_FULL) ? VC_FULL : umbral_V_full;
    assign d_thr_in = (umbral_D_full == '0 || umbral_D_full > D_FULL) ? D_FULL : umbral_D_full;
    assign v_thr_nxt = (state == ST_INIT) ? v_thr_in : v_thr;

    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            vc_head[i]  = vc_mem[i][vc_rd[i]];
            eligible[i] = (vc_cnt[i] != '0) && (d_cnt[vc_head[i][DEST_W-1:0]] < d_thr);
        end
    end

    // Descending scan so the lowest search offset wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_vc    = '0;
        scan_idx  = '0;
        for (int k = NUM_VC - 1; k >= 0; k--) begin
`ifdef VC_STRICT_PRIO_EN
            scan_idx = VC_W'(k);
`else
            scan_idx = rr_ptr + VC_W'(k);
`endif
            if (run && eligible[scan_idx]) begin
                gnt_valid = 1'b1;
                gnt_vc    = scan_idx;
            end
        end
    end

    assign gnt_word = vc_head[gnt_vc];
    assign gnt_dest = gnt_word[DEST_W-1:0];

    always_comb begin
        err_set   = '0;
        any_busy  = 1'b0;
        pause_nxt = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            vc_re[i] = gnt_valid && (gnt_vc == VC_W'(i));
            vc_we[i] = push_ok && (push_vc == VC_W'(i)) && (vc_cnt[i] != VC_FULL);
            if (push_ok && (push_vc == VC_W'(i)) && (vc_cnt[i] == VC_FULL))
                err_set[i] = 1'b1;
            vc_cnt_nxt[i] = vc_cnt[i] + PTR_L'(vc_we[i]) - PTR_L'(vc_re[i]);
            if (vc_cnt[i] != '0)
                any_busy = 1'b1;
            if ((v_thr_nxt != '0) && (vc_cnt_nxt[i] >= v_thr_nxt))
                pause_nxt = 1'b1;
        end
        for (int j = 0; j < NUM_DEST; j++) begin
            d_we[j] = gnt_valid && (gnt_dest == DEST_W'(j)) && (d_cnt[j] != D_FULL);
            d_re[j] = pop_D[j] && (d_cnt[j] != '0);
            if ((gnt_valid && (gnt_dest == DEST_W'(j)) && (d_cnt[j] == D_FULL)) ||
                (pop_D[j] && (d_cnt[j] == '0)))
                err_set[NUM_VC+j] = 1'b1;
            d_cnt_nxt[j] = d_cnt[j] + PTR_L'(d_we[j]) - PTR_L'(d_re[j]);
            if (d_cnt[j] != '0)
                any_busy = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_RESET;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET:  state_nxt = ST_INIT;
            ST_INIT:   state_nxt = init ? ST_INIT : ST_IDLE;
            ST_IDLE, ST_ACTIVE: begin
                if (err_set != '0)
                    state_nxt = ST_ERROR;
                else if (init)
                    state_nxt = ST_INIT;
                else
                    state_nxt = any_busy ? ST_ACTIVE : ST_IDLE;
            end
            ST_ERROR:  state_nxt = ST_ERROR;
            default:   state_nxt = ST_RESET;
        endcase
    end

    always_comb begin
        error_out  = (state == ST_ERROR);
        active_out = (state == ST_ACTIVE);
        idle_out   = (state == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_thr       <= '0;
            d_thr       <= '0;
            errors      <= '0;
            input_pause <= 1'b0;
`ifndef VC_STRICT_PRIO_EN
            rr_ptr      <= '0;
`endif
            for (int i = 0; i < NUM_VC; i++) begin
                vc_rd[i]  <= '0;
                vc_wr[i]  <= '0;
                vc_cnt[i] <= '0;
            end
            for (int j = 0; j < NUM_DEST; j++) begin
                d_rd[j]  <= '0;
                d_wr[j]  <= '0;
                d_cnt[j] <= '0;
            end
        end else begin
            if (state == ST_INIT) begin
                v_thr <= v_thr_in;
                d_thr <= d_thr_in;
            end
            errors      <= errors | err_set;
            input_pause <= pause_nxt;
`ifndef VC_STRICT_PRIO_EN
            if (gnt_valid)
                rr_ptr <= gnt_vc + VC_W'(1);
`endif
            for (int i = 0; i < NUM_VC; i++) begin
                if (vc_we[i])
                    vc_wr[i] <= vc_inc(vc_wr[i]);
                if (vc_re[i])
                    vc_rd[i] <= vc_inc(vc_rd[i]);
                vc_cnt[i] <= vc_cnt_nxt[i];
            end
            for (int j = 0; j < NUM_DEST; j++) begin
                if (d_we[j])
                    d_wr[j] <= d_inc(d_wr[j]);
                if (d_re[j])
                    d_rd[j] <= d_inc(d_rd[j]);
                d_cnt[j] <= d_cnt_nxt[j];
            end
        end
    end

    // Storage needs no reset: empty FIFOs never expose their contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_VC; i++)
            if (vc_we[i])
                vc_mem[i][vc_wr[i]] <= data_in;
        for (int j = 0; j < NUM_DEST; j++)
            if (d_we[j])
                d_mem[j][d_wr[j]] <= gnt_word;
    end

    always_comb begin
        for (int j = 0; j < NUM_DEST; j++) begin
            d_empty[j] = (d_cnt[j] == '0);
            data_out[j*WORD_SIZE +: WORD_SIZE] = (d_cnt[j] == '0) ? '0 : d_mem[j][d_rd[j]];
        end
    end

endmodule

// File: tb/tb_pcie_vc_switch.sv
// tb/tb_pcie_vc_switch.sv - directed and randomized bench for pcie_vc_switch against a queue-based model
module tb_pcie_vc_switch;
    localparam int WS = 6;
    localparam int NV = 4;
    localparam int ND = 4;
    localparam int VD = 16;
    localparam int DD = 4;
    localparam int PL = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             init = 1'b0;
    logic [PL-1:0]    umbral_V_full = '0;
    logic [PL-1:0]    umbral_D_full = '0;
    logic [WS-1:0]    data_in = '0;
    logic             push_data_in = 1'b0;
    logic             input_pause;
    logic [ND-1:0]    pop_D = '0;
    logic [ND*WS-1:0] data_out;
    logic [ND-1:0]    d_empty;
    logic [NV+ND-1:0] errors;
    logic             error_out, active_out, idle_out;
    logic [2:0]       state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [WS-1:0]    m_vq [NV][$];
    logic [WS-1:0]    m_dq [ND][$];
    int               m_state = 0;
    int               m_vthr = 0;
    int               m_dthr = 0;
    int               m_rr = 0;
    logic [NV+ND-1:0] m_err = '0;
    logic             m_pause = 1'b0;
    logic [WS-1:0]    rr_exp [5];

    pcie_vc_switch #(.WORD_SIZE(WS), .NUM_VC(NV), .NUM_DEST(ND), .VC_DEPTH(VD),
                     .D_DEPTH(DD), .PTR_L(PL)) dut (
        .clk(clk), .reset(reset), .init(init),
        .umbral_V_full(umbral_V_full), .umbral_D_full(umbral_D_full),
        .data_in(data_in), .push_data_in(push_data_in), .input_pause(input_pause),
        .pop_D(pop_D), .data_out(data_out), .d_empty(d_empty), .errors(errors),
        .error_out(error_out), .active_out(active_out), .idle_out(idle_out),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp(input int u, input int depth);
        return (u == 0 || u > depth) ? depth : u;
    endfunction

    // One clock of the switch, as the rules describe it, using pre-edge occupancy.
    task automatic model_step();
        int vs [NV];
        int ds [ND];
        int g, idx, vc, dst;
        bit busy, pause;
        logic [NV+ND-1:0] ne;
        logic [WS-1:0] w;
        if (reset) begin
            for (int i = 0; i < NV; i++) m_vq[i].delete();
            for (int j = 0; j < ND; j++) m_dq[j].delete();
            m_state = 0; m_vthr = 0; m_dthr = 0; m_rr = 0; m_err = '0; m_pause = 1'b0;
            return;
        end
        busy = 0;
        for (int i = 0; i < NV; i++) begin vs[i] = m_vq[i].size(); if (vs[i] > 0) busy = 1; end
        for (int j = 0; j < ND; j++) begin ds[j] = m_dq[j].size(); if (ds[j] > 0) busy = 1; end
        g = -1;
        if (m_state == 2 || m_state == 3) begin
            for (int k = 0; k < NV && g < 0; k++) begin
`ifdef VC_STRICT_PRIO_EN
                idx = k;
`else
                idx = (m_rr + k) % NV;
`endif
                if (vs[idx] > 0 && ds[int'(m_vq[idx][0]) % ND] < m_dthr) g = idx;
            end
        end
        ne = '0;
        for (int j = 0; j < ND; j++)
            if (pop_D[j]) begin
                if (ds[j] == 0) ne[NV+j] = 1'b1;
                else void'(m_dq[j].pop_front());
            end
        if (g >= 0) begin
            w = m_vq[g].pop_front();
            dst = int'(w) % ND;
            if (ds[dst] >= DD) ne[NV+dst] = 1'b1;
            else m_dq[dst].push_back(w);
            m_rr = (g + 1) % NV;
        end
        if (push_data_in && (m_state == 1 || m_state == 2 || m_state == 3)) begin
            vc = int'(data_in) / (1 << (WS - $clog2(NV)));
            if (vs[vc] >= VD) ne[vc] = 1'b1;
            else m_vq[vc].push_back(data_in);
        end
        if (m_state == 1) begin
            m_vthr = clamp(int'(umbral_V_full), VD);
            m_dthr = clamp(int'(umbral_D_full), DD);
        end
        case (m_state)
            0: m_state = 1;
            1: m_state = init ? 1 : 2;
            2, 3: m_state = (ne != '0) ? 4 : (init ? 1 : (busy ? 3 : 2));
            default: m_state = 4;
        endcase
        m_err = m_err | ne;
        pause = 0;
        for (int i = 0; i < NV; i++)
            if (m_vthr != 0 && m_vq[i].size() >= m_vthr) pause = 1;
        m_pause = pause;
    endtask

    task automatic compare_all();
        logic [ND*WS-1:0] exp_do;
        logic [ND-1:0]    exp_e;
        exp_do = '0;
        for (int j = 0; j < ND; j++) begin
            exp_e[j] = (m_dq[j].size() == 0);
            if (m_dq[j].size() != 0) exp_do[j*WS +: WS] = m_dq[j][0];
        end
        check("state", 64'(state), 64'(m_state));
        check("errors", 64'(errors), 64'(m_err));
        check("input_pause", 64'(input_pause), 64'(m_pause));
        check("d_empty", 64'(d_empty), 64'(exp_e));
        check("data_out", 64'(data_out), 64'(exp_do));
        check("status_flags", 64'({error_out, active_out, idle_out}),
              64'({m_state == 4, m_state == 3, m_state == 2}));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic init_seq(input int v, input int d);
        reset = 1'b1; init = 1'b0; push_data_in = 1'b0; pop_D = '0;
        tick();
        check("rst_state", 64'(state), 64'd0);
        check("rst_d_empty", 64'(d_empty), 64'hF);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_pause_err", 64'({input_pause, error_out, errors}), 64'd0);
        reset = 1'b0; init = 1'b1;
        umbral_V_full = PL'(v); umbral_D_full = PL'(d);
        tick();
        check("init_state", 64'(state), 64'd1);
        tick();
        init = 1'b0;
        tick();
        check("idle_state", 64'(state), 64'd2);
    endtask

    task automatic push_word(input logic [WS-1:0] w);
        data_in = w; push_data_in = 1'b1;
        tick();
        push_data_in = 1'b0;
    endtask

    task automatic pop_when_ready(input int j, input string tag, output logic [WS-1:0] w);
        int waited = 0;
        while (d_empty[j] && waited < 20) begin tick(); waited++; end
        check({tag, "_wait"}, 64'(waited < 20), 64'd1);
        w = data_out[j*WS +: WS];
        pop_D = ND'(1) << j;
        tick();
        pop_D = '0;
    endtask

    initial begin
        logic [WS-1:0] w;
`ifdef VC_STRICT_PRIO_EN
        rr_exp[0] = 6'h00; rr_exp[1] = 6'h04; rr_exp[2] = 6'h10; rr_exp[3] = 6'h20; rr_exp[4] = 6'h30;
`else
        rr_exp[0] = 6'h00; rr_exp[1] = 6'h10; rr_exp[2] = 6'h20; rr_exp[3] = 6'h30; rr_exp[4] = 6'h04;
`endif
        // Basic path
        init_seq(8, 2);
        push_word(6'h23);
        tick();
        check("basic_dout3", 64'(data_out[3*WS +: WS]), 64'h23);
        check("basic_empty3", 64'(d_empty[3]), 64'd0);
        check("basic_active", 64'(state), 64'd3);
        pop_D = 4'b1000; tick(); pop_D = '0;
        check("basic_popped", 64'(d_empty[3]), 64'd1);
        tick();
        check("basic_idle", 64'(state), 64'd2);

        // Arbitration order
        init_seq(16, 1);
        push_word(6'h00); push_word(6'h30); push_word(6'h20); push_word(6'h10); push_word(6'h04);
        for (int n = 0; n < 5; n++) begin
            pop_when_ready(0, "rr", w);
            check("rr_order", 64'(w), 64'(rr_exp[n]));
        end

        // Input pause
        init_seq(3, 1);
        push_word(6'h11); tick(); tick();
        push_word(6'h11); push_word(6'h11);
        check("pause_below", 64'(input_pause), 64'd0);
        push_word(6'h11);
        check("pause_set", 64'(input_pause), 64'd1);
        for (int n = 0; n < 4; n++) pop_when_ready(1, "pause_drain", w);
        tick();
        check("pause_clear", 64'(input_pause), 64'd0);
        check("pause_all_empty", 64'(d_empty), 64'hF);

        // VC overflow
        init_seq(16, 1);
        push_word(6'h10);
        for (int n = 0; n < 17; n++) push_word(6'h00);
        check("ovf_err", 64'(errors), 64'h01);
        check("ovf_state", 64'({error_out, state}), 64'({1'b1, 3'd4}));
        for (int n = 0; n < 3; n++) push_word(6'h00);
        check("ovf_sticky", 64'(errors), 64'h01);
        reset = 1'b1; tick(); reset = 1'b0;
        check("ovf_reset", 64'({errors, state}), 64'd0);

        // Destination underflow, pops still served in ERROR
        init_seq(16, 4);
        push_word(6'h00); tick();
        pop_D = 4'b0100; tick(); pop_D = '0;
        check("udf_err", 64'(errors), 64'h40);
        check("udf_state", 64'(state), 64'd4);
        pop_D = 4'b0001; tick(); pop_D = '0;
        check("udf_drain", 64'(d_empty[0]), 64'd1);

        // Reset with traffic in flight
        init_seq(16, 1);
        push_word(6'h00); push_word(6'h01); push_word(6'h12); push_word(6'h23); push_word(6'h30);
        reset = 1'b1; tick(); reset = 1'b0;
        check("mid_rst", 64'({d_empty, input_pause, state}), 64'({4'hF, 1'b0, 3'd0}));
        for (int n = 0; n < 10; n++) tick();
        check("mid_rst_nodata", 64'({d_empty, errors}), 64'({4'hF, 8'h00}));

        // Randomized traffic
        init_seq(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
        for (int c = 0; c < 4000; c++) begin
            reset = (m_state == 4) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 999) == 0);
            init = ($urandom_range(0, 249) == 0);
            umbral_V_full = PL'($urandom_range(0, 31));
            umbral_D_full = PL'($urandom_range(0, 31));
            data_in = WS'($urandom);
            push_data_in = ($urandom_range(0, 1) == 1);
            for (int j = 0; j < ND; j++)
                pop_D[j] = (m_dq[j].size() > 0) ? ($urandom_range(0, 2) != 0)
                                                : ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0; init = 1'b0; push_data_in = 1'b0; pop_D = '0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
